// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared opcodes, ALU bus request codes and FSM states for alu_sequencer
package alu_seq_pkg;

    localparam logic [3:0] OP_ADDI   = 4'd1;
    localparam logic [3:0] OP_ADD    = 4'd2;
    localparam logic [3:0] REQ_NEXT  = 4'b0011;
    localparam logic [3:0] REQ_VALUE = 4'b0001;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        WB,
        ABORT,
        RSP
    } state_t;

    function automatic logic is_legal_op(input logic [3:0] op);
        return (op == OP_ADDI) || (op == OP_ADD);
    endfunction

endpackage

// File: rtl/alu_seq_regfile.sv
// rtl/alu_seq_regfile.sv - 4x4-bit register file, one write port, two operand reads and a debug read
module alu_seq_regfile (
    input  logic       clk,
    input  logic       rst,
    input  logic       we,
    input  logic [1:0] waddr,
    input  logic [3:0] wdata,
    input  logic [1:0] ra1,
    input  logic [1:0] ra2,
    input  logic [1:0] dbg_addr,
    output logic [3:0] rd1,
    output logic [3:0] rd2,
    output logic [3:0] dbg_data
);

    logic [3:0] rf_q [4];
    logic [3:0] rf_d [4];

    always_comb begin
        rf_d = rf_q;
        if (we) begin
            rf_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                rf_q[i] <= 4'd0;
            end
        end else begin
            rf_q <= rf_d;
        end
    end

    assign rd1      = rf_q[ra1];
    assign rd2      = rf_q[ra2];
    assign dbg_data = rf_q[dbg_addr];

endmodule

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - ADD/ADDI command sequencer for the 4-bit ALU; ALU_SEQ_TIMEOUT_EN adds RUN timeout/abort
module alu_sequencer
    import alu_seq_pkg::*;
`ifdef ALU_SEQ_TIMEOUT_EN
#(
    parameter int unsigned TIMEOUT_CYCLES = 15
)
`endif
(
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_op,
    input  logic [1:0] cmd_rd,
    input  logic [1:0] cmd_rs1,
    input  logic [1:0] cmd_rs2,
    input  logic [3:0] cmd_imm,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [3:0] rsp_data,
    output logic       rsp_carry,
    output logic       rsp_err,
    output logic [3:0] alu_opcode,
    output logic [3:0] alu_mio,
    input  logic [3:0] alu_bus_req,
    output logic [3:0] alu_operand,
    input  logic [3:0] alu_result,
    output logic       alu_oe_n,
    input  logic       alu_carry,
    input  logic       alu_done,
    output logic       alu_rst_n,
    input  logic [1:0] dbg_addr,
    output logic [3:0] dbg_data
);

    state_t     state_q, state_d;
    logic [3:0] op_q, op_d;
    logic [1:0] rd_q, rd_d;
    logic [1:0] rs1_q, rs1_d;
    logic [1:0] rs2_q, rs2_d;
    logic [3:0] imm_q, imm_d;
    logic       slot_q, slot_d;
    logic [3:0] prev_req_q, prev_req_d;
    logic [3:0] rsp_data_q, rsp_data_d;
    logic       rsp_carry_q, rsp_carry_d;
    logic       rsp_err_q, rsp_err_d;
    logic       rf_we;
    logic [3:0] rs1_val, rs2_val;
`ifdef ALU_SEQ_TIMEOUT_EN
    logic [7:0] tcnt_q, tcnt_d;
`endif

    alu_seq_regfile u_regfile (
        .clk      (clk),
        .rst      (rst),
        .we       (rf_we),
        .waddr    (rd_q),
        .wdata    (rsp_data_q),
        .ra1      (rs1_q),
        .ra2      (rs2_q),
        .dbg_addr (dbg_addr),
        .rd1      (rs1_val),
        .rd2      (rs2_val),
        .dbg_data (dbg_data)
    );

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        rd_d        = rd_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        imm_d       = imm_q;
        slot_d      = slot_q;
        prev_req_d  = alu_bus_req;
        rsp_data_d  = rsp_data_q;
        rsp_carry_d = rsp_carry_q;
        rsp_err_d   = rsp_err_q;
        rf_we       = 1'b0;
`ifdef ALU_SEQ_TIMEOUT_EN
        tcnt_d      = tcnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    op_d      = cmd_op;
                    rd_d      = cmd_rd;
                    rs1_d     = cmd_rs1;
                    rs2_d     = cmd_rs2;
                    imm_d     = cmd_imm;
                    slot_d    = 1'b0;
                    rsp_err_d = 1'b0;
`ifdef ALU_SEQ_TIMEOUT_EN
                    tcnt_d    = 8'd0;
`endif
                    if (is_legal_op(cmd_op)) begin
                        state_d = RUN;
                    end else begin
                        rsp_err_d = 1'b1;
                        state_d   = RSP;
                    end
                end
            end
            RUN: begin
                // Only the rising edge of a next-operand request moves to the rs1 slot.
                if (alu_bus_req == REQ_NEXT && prev_req_q != REQ_NEXT) begin
                    slot_d = 1'b1;
                end
                if (alu_done) begin
                    rsp_data_d  = alu_result;
                    rsp_carry_d = alu_carry;
                    state_d     = WB;
                end
`ifdef ALU_SEQ_TIMEOUT_EN
                else if (tcnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
                    state_d = ABORT;
                end else begin
                    tcnt_d = tcnt_q + 8'd1;
                end
`endif
            end
            WB: begin
                rf_we   = 1'b1;
                state_d = RSP;
            end
`ifdef ALU_SEQ_TIMEOUT_EN
            ABORT: begin
                rsp_err_d = 1'b1;
                state_d   = RSP;
            end
`endif
            RSP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            op_q        <= 4'd0;
            rd_q        <= 2'd0;
            rs1_q       <= 2'd0;
            rs2_q       <= 2'd0;
            imm_q       <= 4'd0;
            slot_q      <= 1'b0;
            prev_req_q  <= 4'd0;
            rsp_data_q  <= 4'd0;
            rsp_carry_q <= 1'b0;
            rsp_err_q   <= 1'b0;
`ifdef ALU_SEQ_TIMEOUT_EN
            tcnt_q      <= 8'd0;
`endif
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            rd_q        <= rd_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            imm_q       <= imm_d;
            slot_q      <= slot_d;
            prev_req_q  <= prev_req_d;
            rsp_data_q  <= rsp_data_d;
            rsp_carry_q <= rsp_carry_d;
            rsp_err_q   <= rsp_err_d;
`ifdef ALU_SEQ_TIMEOUT_EN
            tcnt_q      <= tcnt_d;
`endif
        end
    end

    assign cmd_ready   = (state_q == IDLE) && !rst;
    assign rsp_valid   = (state_q == RSP);
    assign rsp_data    = rsp_data_q;
    assign rsp_carry   = rsp_carry_q;
    assign rsp_err     = rsp_err_q;
    // Gated by done combinationally so the ALU never sees a restart on its done cycle.
    assign alu_opcode  = (state_q == RUN && !alu_done) ? op_q : 4'd0;
    assign alu_mio     = (state_q == RUN) ? imm_q : 4'd0;
    assign alu_oe_n    = (state_q != RUN);
    assign alu_operand = (state_q == RUN) ? (slot_q ? rs1_val : rs2_val) : 4'd0;
`ifdef ALU_SEQ_TIMEOUT_EN
    assign alu_rst_n   = !rst && (state_q != ABORT);
`else
    assign alu_rst_n   = !rst;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - directed scoreboard bench for alu_sequencer with a behavioural ALU model
module tb_alu_sequencer;
    import alu_seq_pkg::*;

    localparam int TOUT = 15;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_op;
    logic [1:0] cmd_rd, cmd_rs1, cmd_rs2;
    logic [3:0] cmd_imm;
    logic       rsp_valid, rsp_ready;
    logic [3:0] rsp_data;
    logic       rsp_carry, rsp_err;
    logic [3:0] alu_opcode, alu_mio, alu_bus_req, alu_operand;
    logic [3:0] alu_result = 4'd0;
    logic       alu_oe_n;
    logic       alu_carry = 1'b0;
    logic       alu_done = 1'b0;
    logic       alu_rst_n;
    logic [1:0] dbg_addr;
    logic [3:0] dbg_data;

    always #5 clk = ~clk;

    alu_sequencer dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_imm(cmd_imm),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_carry(rsp_carry), .rsp_err(rsp_err),
        .alu_opcode(alu_opcode), .alu_mio(alu_mio), .alu_bus_req(alu_bus_req),
        .alu_operand(alu_operand), .alu_result(alu_result), .alu_oe_n(alu_oe_n),
        .alu_carry(alu_carry), .alu_done(alu_done), .alu_rst_n(alu_rst_n),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] data;
        logic       carry;
        logic       err;
    } exp_t;

    exp_t       sb [$];
    logic [3:0] model_rf [4];
    logic [3:0] ops_seen [$];

    // Behavioural ALU: ADDI = NEXT, VALUE, done at step 4; ADD = VALUE, NEXT, VALUE, done at step 5.
    logic       hang = 1'b0;
    logic       m_busy = 1'b0;
    logic [2:0] m_cnt = 3'd0;
    logic [3:0] m_op = 4'd0, m_imm = 4'd0, m_v0 = 4'd0, m_v1 = 4'd0;
    logic       m_nv = 1'b0;

    always_comb begin
        alu_bus_req = 4'd0;
        if (m_busy) begin
            if (m_op == OP_ADD) begin
                if (m_cnt == 3'd1 || m_cnt == 3'd3) alu_bus_req = REQ_VALUE;
                else if (m_cnt == 3'd2)             alu_bus_req = REQ_NEXT;
            end else begin
                if (m_cnt == 3'd1)      alu_bus_req = REQ_NEXT;
                else if (m_cnt == 3'd2) alu_bus_req = REQ_VALUE;
            end
        end
    end

    always @(posedge clk) begin
        if (!alu_rst_n) begin
            m_busy   <= 1'b0;
            m_cnt    <= 3'd0;
            alu_done <= 1'b0;
        end else begin
            alu_done <= 1'b0;
            if (!m_busy) begin
                if (alu_opcode != 4'd0 && !hang) begin
                    m_busy <= 1'b1;
                    m_cnt  <= 3'd1;
                    m_op   <= alu_opcode;
                    m_imm  <= alu_mio;
                    m_nv   <= 1'b0;
                end
            end else begin
                if (alu_bus_req == REQ_VALUE) begin
                    if (!m_nv) m_v0 <= alu_operand;
                    else       m_v1 <= alu_operand;
                    m_nv <= 1'b1;
                    ops_seen.push_back(alu_operand);
                end
                if (m_cnt == ((m_op == OP_ADD) ? 3'd5 : 3'd4)) begin
                    {alu_carry, alu_result} <= (m_op == OP_ADD) ? ({1'b0, m_v0} + {1'b0, m_v1})
                                                                : ({1'b0, m_v0} + {1'b0, m_imm});
                    alu_done <= 1'b1;
                    m_busy   <= 1'b0;
                end else begin
                    m_cnt <= m_cnt + 3'd1;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_rf(input string tag);
        for (int a = 0; a < 4; a++) begin
            dbg_addr = 2'(a);
            #1;
            check($sformatf("%s dbg r%0d", tag, a), 32'(dbg_data), 32'(model_rf[a]));
        end
    endtask

    task automatic run_cmd(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                           input logic [1:0] rs2, input logic [3:0] imm, input int hold,
                           input string tag);
        exp_t       e, got;
        int         k, exp_lat;
        bit         legal, aborted;
        logic [4:0] sum;
        legal   = (op == OP_ADDI) || (op == OP_ADD);
        aborted = legal && hang;
        sum     = (op == OP_ADD) ? ({1'b0, model_rf[rs1]} + {1'b0, model_rf[rs2]})
                                 : ({1'b0, model_rf[rs1]} + {1'b0, imm});
        e.data  = sum[3:0];
        e.carry = sum[4];
        e.err   = !legal || aborted;
        exp_lat = !legal ? 1 : aborted ? TOUT + 2 : (op == OP_ADD ? 9 : 8);
        sb.push_back(e);

        check({tag, " cmd_ready idle"}, 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_imm = imm;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (k = 1; k <= 40; k++) begin
            if (k == 1) begin
                check({tag, " opcode T+1"}, 32'(alu_opcode), legal ? 32'(op) : 32'd0);
                check({tag, " oe_n T+1"}, 32'(alu_oe_n), legal ? 32'd0 : 32'd1);
                if (legal) check({tag, " mio T+1"}, 32'(alu_mio), 32'(imm));
            end
            if (legal && !aborted && k == exp_lat - 2) begin
                check({tag, " done seen"}, 32'(alu_done), 32'd1);
                check({tag, " opcode gated on done"}, 32'(alu_opcode), 32'd0);
            end
            if (aborted && k == exp_lat - 2) check({tag, " alu_rst_n before abort"}, 32'(alu_rst_n), 32'd1);
            if (aborted && k == exp_lat - 1) check({tag, " alu_rst_n in abort"}, 32'(alu_rst_n), 32'd0);
            if (rsp_valid) break;
            @(negedge clk);
        end
        check({tag, " rsp latency"}, 32'(k), 32'(exp_lat));
        got = sb.pop_front();
        if (rsp_valid) begin
            check({tag, " rsp_err"}, 32'(rsp_err), 32'(got.err));
            if (!got.err) begin
                check({tag, " rsp_data"}, 32'(rsp_data), 32'(got.data));
                check({tag, " rsp_carry"}, 32'(rsp_carry), 32'(got.carry));
            end
            if (aborted) check({tag, " alu_rst_n after abort"}, 32'(alu_rst_n), 32'd1);
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check({tag, " hold rsp_valid"}, 32'(rsp_valid), 32'd1);
            check({tag, " hold cmd_ready"}, 32'(cmd_ready), 32'd0);
            check({tag, " hold rsp_err"}, 32'(rsp_err), 32'(got.err));
            if (!got.err) check({tag, " hold rsp_data"}, 32'(rsp_data), 32'(got.data));
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check({tag, " rsp_valid after hs"}, 32'(rsp_valid), 32'd0);
        check({tag, " cmd_ready after hs"}, 32'(cmd_ready), 32'd1);
        if (legal && !aborted) model_rf[rd] = sum[3:0];
        check_rf(tag);
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 4'd0; cmd_rd = 2'd0; cmd_rs1 = 2'd0;
        cmd_rs2 = 2'd0; cmd_imm = 4'd0; rsp_ready = 1'b0; dbg_addr = 2'd0;
        for (int a = 0; a < 4; a++) model_rf[a] = 4'd0;
        repeat (3) @(negedge clk);
        check("reset alu_rst_n", 32'(alu_rst_n), 32'd0);
        check("reset cmd_ready", 32'(cmd_ready), 32'd0);
        check("reset rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset alu_oe_n", 32'(alu_oe_n), 32'd1);
        check("reset alu_opcode", 32'(alu_opcode), 32'd0);
        check_rf("reset");
        rst = 1'b0;
        @(negedge clk);
        check("post reset cmd_ready", 32'(cmd_ready), 32'd1);
        check("post reset alu_rst_n", 32'(alu_rst_n), 32'd1);

        run_cmd(OP_ADDI, 2'd1, 2'd0, 2'd0, 4'd7, 0, "addi r1=7");
        run_cmd(OP_ADDI, 2'd2, 2'd1, 2'd0, 4'd9, 0, "addi wrap");
        run_cmd(OP_ADDI, 2'd1, 2'd0, 2'd0, 4'd5, 0, "addi r1=5");
        run_cmd(OP_ADDI, 2'd2, 2'd0, 2'd0, 4'd3, 0, "addi r2=3");
        ops_seen.delete();
        run_cmd(OP_ADD, 2'd3, 2'd1, 2'd2, 4'd0, 5, "add r3");
        check("add operand count", 32'(ops_seen.size()), 32'd2);
        if (ops_seen.size() == 2) begin
            check("add operand first", 32'(ops_seen[0]), 32'd3);
            check("add operand second", 32'(ops_seen[1]), 32'd5);
        end
        run_cmd(4'd4, 2'd0, 2'd1, 2'd2, 4'd0, 0, "illegal op");
        for (int i = 0; i < 4; i++) begin
            run_cmd(($urandom_range(1) == 0) ? OP_ADDI : OP_ADD, 2'($urandom_range(3)),
                    2'($urandom_range(3)), 2'($urandom_range(3)), 4'($urandom_range(15)),
                    0, $sformatf("rand%0d", i));
        end
`ifdef ALU_SEQ_TIMEOUT_EN
        hang = 1'b1;
        run_cmd(OP_ADDI, 2'd0, 2'd1, 2'd0, 4'd1, 0, "timeout");
        hang = 1'b0;
`endif

        cmd_valid = 1'b1; cmd_op = OP_ADD; cmd_rd = 2'd3; cmd_rs1 = 2'd1; cmd_rs2 = 2'd2;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst rsp_valid", 32'(rsp_valid), 32'd0);
        check("midrst rsp_data", 32'(rsp_data), 32'd0);
        check("midrst rsp_carry", 32'(rsp_carry), 32'd0);
        check("midrst rsp_err", 32'(rsp_err), 32'd0);
        check("midrst alu_opcode", 32'(alu_opcode), 32'd0);
        check("midrst alu_mio", 32'(alu_mio), 32'd0);
        check("midrst alu_operand", 32'(alu_operand), 32'd0);
        check("midrst alu_oe_n", 32'(alu_oe_n), 32'd1);
        check("midrst cmd_ready", 32'(cmd_ready), 32'd0);
        check("midrst alu_rst_n", 32'(alu_rst_n), 32'd0);
        for (int a = 0; a < 4; a++) model_rf[a] = 4'd0;
        check_rf("midrst");
        rst = 1'b0;
        @(negedge clk);
        check("after midrst cmd_ready", 32'(cmd_ready), 32'd1);
        run_cmd(OP_ADDI, 2'd0, 2'd0, 2'd0, 4'd15, 0, "after midrst");
        check("scoreboard empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Command-level controller for the 4-bit ALU coprocessor. Accepts ADD/ADDI commands over a valid/ready port and owns a 4×4-bit register file. It drives the ALU's opcode, immediate and output-enable lines, and serves the ALU's bus-request protocol with operand values. It captures result and carry on done, writes the result back, and returns a response. It sits between the host-side command source and the ALU.

## Interface
- TIMEOUT_CYCLES, 15: RUN cycles allowed before abort (only with timeout feature); range 8–255.
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high only in IDLE
- cmd_op  in  4  1 = ADDI, 2 = ADD; all other values are illegal
- cmd_rd  in  2  destination register
- cmd_rs1  in  2  first source register
- cmd_rs2  in  2  second source register (ADD only)
- cmd_imm  in  4  immediate (ADDI only)
- rsp_valid  out  1  response held until accepted
- rsp_ready  in  1  response accepted
- rsp_data  out  4  result
- rsp_carry  out  1  carry out of the 4-bit add
- rsp_err  out  1  illegal opcode or timeout
- alu_opcode  out  4  to ALU opcode input
- alu_mio  out  4  to ALU immediate input
- alu_bus_req  in  4  ALU bus request; 4'b0011 = next operand, 4'b0001 = value strobe
- alu_operand  out  4  operand value driven onto the ALU bus input
- alu_result  in  4  ALU bus output
- alu_oe_n  out  1  ALU output enable, active low
- alu_carry  in  1  ALU carry
- alu_done  in  1  ALU done (registered level)
- alu_rst_n  out  1  ALU reset, active low
- dbg_addr  in  2  debug read address
- dbg_data  out  4  register file contents at dbg_addr (combinational)

## Operation
- States:
  - IDLE: accept command.
    - Legal opcode → RUN.
    - Illegal opcode → RSP with rsp_err=1, no ALU activity, no writeback.
  - RUN: serve operands and wait for done.
    - alu_done=1 → WB.
    - With the timeout feature, a timeout → ABORT.
  - WB: write rsp_data to rf[rd] → RSP.
  - ABORT: alu_rst_n=0 for one cycle, rsp_err=1 → RSP.
  - RSP: rsp_valid=1; rsp_valid & rsp_ready → IDLE.
- On accept, latch op, rd, rs1, rs2, imm; clear slot=0 and err.
- alu_opcode = op_q when state==RUN && !alu_done, else 0. The gate is combinational so the ALU cannot restart on the cycle it reports done.
- alu_mio = imm_q in RUN, else 0.
- alu_oe_n = 0 in RUN, else 1.
- Operand slots:
  - Slot 0 = rf[rs2]; slot 1 = rf[rs1].
  - alu_operand = rf[slot ? rs1 : rs2] during RUN, else 0.
  - slot advances 0→1 when alu_bus_req==4'b0011 and the previously sampled alu_bus_req!=4'b0011. It saturates at 1.
  - The previous-request register is reset to 0 and is not cleared on accept.
- When alu_done=1 in RUN, latch rsp_data=alu_result and rsp_carry=alu_carry.
- Writeback uses 4-bit arithmetic; the carry is only reported, never stored in rf.
- Reset (rst=1, any state, including mid-command):
  - State → IDLE; rf, slot and all response registers → 0.
  - alu_rst_n=0 while rst=1.
  - cmd_ready=0 while rst=1.
- Output values in reset: rsp_valid, rsp_data, rsp_carry, rsp_err, alu_opcode, alu_mio and alu_operand all 0; alu_oe_n=1.
- A new command is never accepted while RSP is held, even if rsp_ready is high in the same cycle. cmd_ready rises the cycle after the handshake.

## Timing
- Command accepted in cycle T; alu_opcode is nonzero from T+1.
- ADDI:
  - alu_done is seen in T+6.
  - alu_opcode=0 in T+6.
  - WB in T+7.
  - rsp_valid from T+8.
- ADD: each of the above is one cycle later (done T+7, rsp_valid T+9).
- Illegal opcode: rsp_valid from T+1.
- Timeout: after TIMEOUT_CYCLES consecutive RUN cycles without done → ABORT, then RSP the next cycle.
- Back-to-back: minimum command spacing is response handshake + 1 cycle.

## Configuration
- ALU_SEQ_TIMEOUT_EN defined:
  - 8-bit RUN-cycle counter, compared against TIMEOUT_CYCLES.
  - ABORT state present.
  - Aborted command does not write rf.
- ALU_SEQ_TIMEOUT_EN undefined:
  - No counter and no ABORT state; RUN waits indefinitely.
  - rsp_err signals an illegal opcode only.
  - alu_rst_n follows only rst.

## Structure
- Package alu_seq_pkg holds:
  - OP_ADDI=4'd1, OP_ADD=4'd2.
  - REQ_NEXT=4'b0011, REQ_VALUE=4'b0001.
  - State enum: IDLE, RUN, WB, ABORT, RSP.
- Sub-module alu_seq_regfile:
  - 4×4-bit, synchronous reset to 0, one write port.
  - Two combinational operand reads plus the debug read.

## Test plan
- Reset, then hold dbg_addr at 0..3 → dbg_data=0 for every register; cmd_ready=1 after reset releases; alu_rst_n=0 during reset.
- Set up r1=7 with ADDI rd=1, rs1=0, imm=7. Then ADDI rd=2, rs1=1, imm=9 → rsp_data=0, rsp_carry=1, r2=0, rsp_valid at T+8.
- With r1=5, r2=3, ADD rd=3, rs1=1, rs2=2 → the ALU sees operand 3 first, then 5. rsp_data=8, carry=0, r3=8.
- cmd_op=4 → rsp_err=1 at T+1; no nonzero alu_opcode; register file unchanged.
- Hold rsp_ready=0 for 5 cycles → rsp fields stable and cmd_ready=0; release → IDLE the next cycle.
- Timeout feature enabled, alu_done tied 0 → after 15 RUN cycles, alu_rst_n low for 1 cycle and rsp_err=1; rf[rd] unchanged. Separately, assert rst mid-ADD → IDLE and all outputs at reset values.
